// File: rtl/sipo.sv
// Serial-in, parallel-out shift register with a word-complete pulse and a bit counter.
// Optional SIPO_HOLD_EN adds q, a register that holds the last completed word.
module sipo #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic [WIDTH-1:0] o,
    output logic             valid,
    output logic [CW-1:0]    count
`ifdef SIPO_HOLD_EN
    ,
    output logic [WIDTH-1:0] q
`endif
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_nxt;
    logic             word_done;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_nxt = {o[WIDTH-2:0], d};
        end else begin : g_lsb
            assign shift_nxt = {d, o[WIDTH-1:1]};
        end
    endgenerate

    // This edge captures the final bit of the current word.
    assign word_done = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o     <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            o     <= shift_nxt;
            valid <= word_done;
            count <= word_done ? '0 : count + CW'(1);
        end
    end

`ifdef SIPO_HOLD_EN
    // Captures the same value o takes on the completing edge, so it lines up with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (word_done)
            q <= shift_nxt;
    end
`endif

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: MSB_FIRST=1 and MSB_FIRST=0 instances share one serial stream.
// Vector table plus hand sequences for reset and mid-word reset; checks q when SIPO_HOLD_EN is set.
module tb_sipo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d = 1'b0;
    logic [3:0] o_m, o_l;
    logic       v_m, v_l;
    logic [1:0] c_m, c_l;
`ifdef SIPO_HOLD_EN
    logic [3:0] q_m, q_l;
`endif

    always #5 clk = ~clk;

    sipo #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .d(d), .o(o_m), .valid(v_m), .count(c_m)
`ifdef SIPO_HOLD_EN
        , .q(q_m)
`endif
    );

    sipo #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .d(d), .o(o_l), .valid(v_l), .count(c_l)
`ifdef SIPO_HOLD_EN
        , .q(q_l)
`endif
    );

    typedef struct {
        logic [3:0] msb;
        logic [3:0] lsb;
        logic       v;
        logic [1:0] cnt;
    } exp_t;

    typedef struct {
        bit         rst_first;
        logic       d;
        exp_t       e;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    exp_t  sb[$];
    vec_t  tbl[17];
    logic [3:0] q_exp_m = 4'b0;
    logic [3:0] q_exp_l = 4'b0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual=%b expected=%b", nm, step_no, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, logic b, logic [3:0] m, logic [3:0] l, logic v, logic [1:0] c);
        vec_t x;
        x.rst_first = r;
        x.d         = b;
        x.e.msb     = m;
        x.e.lsb     = l;
        x.e.v       = v;
        x.e.cnt     = c;
        return x;
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_o_msb"}, o_m, 4'b0);
        chk({nm, "_o_lsb"}, o_l, 4'b0);
        chk({nm, "_valid"}, {2'b0, v_l, v_m}, 4'b0);
        chk({nm, "_count"}, {c_l, c_m}, 4'b0);
`ifdef SIPO_HOLD_EN
        chk({nm, "_q"}, q_m | q_l, 4'b0);
`endif
        q_exp_m = 4'b0;
        q_exp_l = 4'b0;
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d", step_no);
            return;
        end
        e = sb.pop_front();
        chk("o_msb", o_m, e.msb);
        chk("o_lsb", o_l, e.lsb);
        chk("valid_msb", {3'b0, v_m}, {3'b0, e.v});
        chk("valid_lsb", {3'b0, v_l}, {3'b0, e.v});
        chk("count_msb", {2'b0, c_m}, {2'b0, e.cnt});
        chk("count_lsb", {2'b0, c_l}, {2'b0, e.cnt});
        if (e.v) begin
            q_exp_m = e.msb;
            q_exp_l = e.lsb;
        end
`ifdef SIPO_HOLD_EN
        chk("q_msb", q_m, q_exp_m);
        chk("q_lsb", q_l, q_exp_l);
`endif
    endtask

    // Drive on the falling edge, check just after the rising edge.
    task automatic step(input logic b, input exp_t e);
        @(negedge clk);
        d = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        compare();
    endtask

    // Assert reset between edges, check it bites without an edge, release before the next falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Bits 1,0,1,1 from reset
        tbl[0]  = mk(1, 1'b1, 4'b0001, 4'b1000, 1'b0, 2'd1);
        tbl[1]  = mk(0, 1'b0, 4'b0010, 4'b0100, 1'b0, 2'd2);
        tbl[2]  = mk(0, 1'b1, 4'b0101, 4'b1010, 1'b0, 2'd3);
        tbl[3]  = mk(0, 1'b1, 4'b1011, 4'b1101, 1'b1, 2'd0);
        // Back-to-back stream 0,1,0,1,1,0,0,1
        tbl[4]  = mk(1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1);
        tbl[5]  = mk(0, 1'b1, 4'b0001, 4'b1000, 1'b0, 2'd2);
        tbl[6]  = mk(0, 1'b0, 4'b0010, 4'b0100, 1'b0, 2'd3);
        tbl[7]  = mk(0, 1'b1, 4'b0101, 4'b1010, 1'b1, 2'd0);
        tbl[8]  = mk(0, 1'b1, 4'b1011, 4'b1101, 1'b0, 2'd1);
        tbl[9]  = mk(0, 1'b0, 4'b0110, 4'b0110, 1'b0, 2'd2);
        tbl[10] = mk(0, 1'b0, 4'b1100, 4'b0011, 1'b0, 2'd3);
        tbl[11] = mk(0, 1'b1, 4'b1001, 4'b1001, 1'b1, 2'd0);
        // Single 1 walking to the far end, then valid must drop
        tbl[12] = mk(1, 1'b1, 4'b0001, 4'b1000, 1'b0, 2'd1);
        tbl[13] = mk(0, 1'b0, 4'b0010, 4'b0100, 1'b0, 2'd2);
        tbl[14] = mk(0, 1'b0, 4'b0100, 4'b0010, 1'b0, 2'd3);
        tbl[15] = mk(0, 1'b0, 4'b1000, 4'b0001, 1'b1, 2'd0);
        tbl[16] = mk(0, 1'b1, 4'b0001, 4'b1000, 1'b0, 2'd1);

        // Held reset with d toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = ~d;
            @(posedge clk);
            #1;
            chk_zero("rst_held");
        end
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst_first)
                do_reset();
            step(tbl[i].d, tbl[i].e);
        end

        // Mid-word asynchronous reset after two bits, then a full word of ones
        do_reset();
        step(1'b1, '{msb: 4'b0001, lsb: 4'b1000, v: 1'b0, cnt: 2'd1});
        step(1'b1, '{msb: 4'b0011, lsb: 4'b1100, v: 1'b0, cnt: 2'd2});
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_midword");
        #1;
        rst_n = 1'b1;
        step(1'b1, '{msb: 4'b0001, lsb: 4'b1000, v: 1'b0, cnt: 2'd1});
        step(1'b1, '{msb: 4'b0011, lsb: 4'b1100, v: 1'b0, cnt: 2'd2});
        step(1'b1, '{msb: 4'b0111, lsb: 4'b1110, v: 1'b0, cnt: 2'd3});
        step(1'b1, '{msb: 4'b1111, lsb: 4'b1111, v: 1'b1, cnt: 2'd0});
        step(1'b0, '{msb: 4'b1110, lsb: 4'b0111, v: 1'b0, cnt: 2'd1});
        step(1'b0, '{msb: 4'b1100, lsb: 4'b0011, v: 1'b0, cnt: 2'd2});
        step(1'b0, '{msb: 4'b1000, lsb: 4'b0001, v: 1'b0, cnt: 2'd3});
        step(1'b0, '{msb: 4'b0000, lsb: 4'b0000, v: 1'b1, cnt: 2'd0});

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
